// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// fir_mac_scheduler : serial 9-tap FIR, one shared MAC, valid/ready on both sides
// Revision 1.0
// ============================================================================
module fir_mac_scheduler #(
  parameter int DW       = 4,
  parameter int CW       = 3,
  parameter int OW       = 10,
  parameter int COEF_RST = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] Data_in,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_drop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] Data_out,
  output logic          busy
);

  localparam int TAPS = 9;
  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DW-1:0]    hist [TAPS];
  logic [CW-1:0]    coef [TAPS];
  logic [3:0]       idx;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    acc_sum;
  logic [OW-1:0]    data_out_q;
  logic [DW-1:0]    tap_s;
  logic [CW-1:0]    tap_c;
  logic [DW+CW-1:0] prod;
  logic             cfg_in_range;

  assign cfg_in_range = (cfg_addr <= LAST_IDX);
  assign Data_out     = data_out_q;

  // Compare-based tap select keeps the mux free of out-of-range indexing.
  always_comb begin
    tap_s = '0;
    tap_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == 4'(k)) begin
        tap_s = hist[k];
        tap_c = coef[k];
      end
    end
  end

  assign prod    = {{CW{1'b0}}, tap_s} * {{DW{1'b0}}, tap_c};
  assign acc_sum = acc + {{(OW-DW-CW){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (idx == LAST_IDX) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        hist[k] <= '0;
        coef[k] <= CW'(COEF_RST);
      end
      acc        <= '0;
      idx        <= '0;
      data_out_q <= '0;
      cfg_drop   <= 1'b0;
    end else begin
      // Only in-range writes that arrive while busy are reported as dropped.
      cfg_drop <= cfg_we && cfg_in_range && (state != IDLE);
      case (state)
        IDLE: begin
          if (cfg_we && cfg_in_range) begin
            for (int k = 0; k < TAPS; k++) begin
              if (cfg_addr == 4'(k)) begin
                coef[k] <= cfg_data;
              end
            end
          end
          if (in_valid) begin
            hist[0] <= Data_in;
            for (int k = 1; k < TAPS; k++) begin
              hist[k] <= hist[k-1];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 4'd1;
          if (idx == LAST_IDX) begin
            data_out_q <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fir_mac_scheduler : directed vectors with a queue-based output scoreboard
// Revision 1.0
// ============================================================================
module tb_fir_mac_scheduler;

  localparam int DW = 4;
  localparam int CW = 3;
  localparam int OW = 10;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] Data_in   = '0;
  logic          cfg_we    = 1'b0;
  logic [3:0]    cfg_addr  = '0;
  logic [CW-1:0] cfg_data  = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          cfg_drop;
  logic          out_valid;
  logic          busy;
  logic [OW-1:0] Data_out;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lat_q[$];
  int ncount = 0;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;

  fir_mac_scheduler #(.DW(DW), .CW(CW), .OW(OW), .COEF_RST(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Data_in   (Data_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_drop  (cfg_drop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data_out  (Data_out),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: latency on each rising out_valid, data against queue head while valid.
  initial begin
    forever begin
      @(negedge clk);
      ncount++;
      if (reset) begin
        if (in_valid && in_ready) lat_q.push_back(ncount);
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) check("unexpected_out_valid", 1, 0);
          else check("latency", ncount - lat_q.pop_front(), 10);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("out_without_expect", 1, 0);
          end else begin
            check("data_out", int'(Data_out), exp_q[0]);
            if (!out_ready) check("stall_in_ready", int'(in_ready), 0);
            else void'(exp_q.pop_front());
          end
        end
        prev_ov = out_valid;
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  task automatic push(input int d, input int e, input bit expect_out);
    int t;
    t = 0;
    if (expect_out) exp_q.push_back(e);
    in_valid = 1'b1;
    Data_in  = DW'(d);
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("idle_timeout", 0, 1);
  endtask

  task automatic wcfg(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = CW'(v);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  int imp_coef[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int imp_exp[9]  = '{15, 30, 45, 60, 75, 90, 105, 0, 15};
  int max_exp[9]  = '{105, 210, 315, 420, 525, 630, 735, 840, 945};

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_data_out", int'(Data_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_cfg_drop", int'(cfg_drop), 0);
    check("rst_busy", int'(busy), 0);

    // Ramp with unity coefficients, then steady state.
    for (int k = 1; k <= 9; k++) push(15, 15 * k, 1'b1);
    push(15, 135, 1'b1);

    // Single-tap coefficient set.
    wait_idle();
    wcfg(0, 7);
    check("cfg_idle_no_drop", int'(cfg_drop), 0);
    for (int k = 1; k <= 8; k++) wcfg(k, 0);
    push(5, 35, 1'b1);
    for (int k = 0; k < 9; k++) push(0, 0, 1'b1);

    // Impulse response read-back, history is all zero here.
    wait_idle();
    for (int k = 0; k < 9; k++) wcfg(k, imp_coef[k]);
    push(15, imp_exp[0], 1'b1);
    for (int k = 1; k < 9; k++) push(0, imp_exp[k], 1'b1);

    // Maximum value, no wrap.
    wait_idle();
    for (int k = 0; k < 9; k++) wcfg(k, 7);
    for (int k = 0; k < 9; k++) push(15, max_exp[k], 1'b1);

    // Backpressure with a held input sample.
    wait_idle();
    out_ready = 1'b0;
    push(15, 945, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("out_valid_timeout", 0, 1);
    in_valid = 1'b1;
    Data_in  = '0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_busy", int'(busy), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after_release", int'(in_ready), 1);
    push(0, 840, 1'b1);

    // Coefficient write during MAC is dropped.
    wait_idle();
    push(0, 735, 1'b1);
    cfg_we   = 1'b1;
    cfg_addr = 4'd3;
    cfg_data = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("drop_pulse", int'(cfg_drop), 1);
    @(posedge clk); #1;
    check("drop_single", int'(cfg_drop), 0);
    push(0, 630, 1'b1);

    // Out-of-range address in IDLE: no write, no drop.
    wait_idle();
    wcfg(12, 0);
    check("oor_no_drop", int'(cfg_drop), 0);
    push(0, 525, 1'b1);

    // Reset in the middle of MAC.
    wait_idle();
    push(7, 0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    lat_q.delete();
    exp_q.delete();
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_data_out", int'(Data_out), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    push(3, 3, 1'b1);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("drain_timeout", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
